// File: rtl/serial_a_paralelo_align.sv
// rtl/serial_a_paralelo_align.sv - serial-to-byte receiver with COM alignment search and lock
// Optional re-search on misaligned COM hits is enabled by defining RELOCK_EN.
module serial_a_paralelo_align #(
  parameter logic [7:0]  COM_SYMBOL     = 8'hBC,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned MISALIGN_LIMIT = 2
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

  localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

  state_t     state, state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] com_cnt, com_cnt_nxt, com_inc;
  logic [7:0] out_nxt;
  logic       out_valid_nxt;
  logic [7:0] win;
  logic       win_com;
  logic       boundary;

  assign win      = {sr[6:0], in};
  assign win_com  = (win == COM_SYMBOL);
  assign boundary = (bit_cnt == 3'd7);
  assign com_inc  = (com_cnt == 4'hF) ? com_cnt : com_cnt + 4'd1;

`ifdef RELOCK_EN
  localparam logic [3:0] MIS_LIM4 = 4'(MISALIGN_LIMIT);
  logic [3:0] mis_cnt, mis_cnt_nxt, mis_inc;
  assign mis_inc = (mis_cnt == 4'hF) ? mis_cnt : mis_cnt + 4'd1;
`endif

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    com_cnt_nxt   = com_cnt;
    out_nxt       = out;
    out_valid_nxt = 1'b0;
`ifdef RELOCK_EN
    mis_cnt_nxt   = mis_cnt;
`endif
    case (state)
      SEARCH: begin
        if (win_com) begin
          bit_cnt_nxt = 3'd0;
          com_cnt_nxt = 4'd1;
          state_nxt   = (LOCK_CNT4 <= 4'd1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          if (win_com) begin
            com_cnt_nxt = com_inc;
            if (com_inc >= LOCK_CNT4) state_nxt = ACTIVE;
          end else begin
            // an aborted lock restarts the search on the following bit
            state_nxt   = SEARCH;
            com_cnt_nxt = 4'd0;
            bit_cnt_nxt = 3'd0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          out_nxt       = win;
          out_valid_nxt = !win_com;
        end
`ifdef RELOCK_EN
        if (boundary && win_com) begin
          mis_cnt_nxt = 4'd0;
        end else if (!boundary && win_com) begin
          if (mis_inc >= MIS_LIM4) begin
            state_nxt   = SEARCH;
            mis_cnt_nxt = 4'd0;
            bit_cnt_nxt = 3'd0;
            com_cnt_nxt = 4'd0;
          end else begin
            mis_cnt_nxt = mis_inc;
          end
        end
`endif
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      sr        <= 8'h00;
      bit_cnt   <= 3'd0;
      com_cnt   <= 4'd0;
      out       <= 8'h00;
      out_valid <= 1'b0;
`ifdef RELOCK_EN
      mis_cnt   <= 4'd0;
`endif
    end else begin
      sr        <= win;
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
`ifdef RELOCK_EN
      mis_cnt   <= mis_cnt_nxt;
`endif
    end
  end

  always_comb begin
    active = (state == ACTIVE);
  end

endmodule

// File: tb/tb_serial_a_paralelo_align.sv
// tb/tb_serial_a_paralelo_align.sv - scoreboard bench for serial_a_paralelo_align (RELOCK_EN scenario when defined)
module tb_serial_a_paralelo_align;

  logic       clk32f = 1'b0;
  logic       reset  = 1'b0;
  logic       in     = 1'b0;
  logic [7:0] out;
  logic       out_valid;
  logic       active;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] exp_q[$];

  serial_a_paralelo_align dut (
    .clk32f    (clk32f),
    .reset     (reset),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .active    (active)
  );

  always #5 clk32f = ~clk32f;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // monitor: every strobe must match the oldest expected byte
  always @(negedge clk32f) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_strobe: got out=%02h expected no strobe", out);
      end else begin
        chk("strobe_data", out, exp_q.pop_front());
      end
    end
  end

  task automatic send_bit(input logic b);
    in = b;
    @(posedge clk32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_data(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b);
  endtask

  task automatic lock4(input string name);
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'hBC);
      chk(name, {7'd0, active}, (k == 4) ? 8'd1 : 8'd0);
    end
  endtask

  task automatic finish_scenario(input string name);
    @(negedge clk32f);
    #1;
    chk(name, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
    reset = 1'b0;
    in    = 1'b0;
    #1;
    chk("reset_active", {7'd0, active}, 8'd0);
    chk("reset_out", out, 8'h00);
    repeat (2) @(posedge clk32f);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // reset held with a toggling input
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in = i[0];
      @(negedge clk32f);
      chk("rst_out", out, 8'h00);
      chk("rst_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_active", {7'd0, active}, 8'd0);
    end
    @(posedge clk32f);
    #1;
    reset = 1'b1;

    // lock and data
    lock4("lock_active");
    send_data(8'hA5);
    send_data(8'h3C);
    chk("lock_active_held", {7'd0, active}, 8'd1);
    finish_scenario("lock_drained");

    // arbitrary bit offset before the COMs
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock4("offset_active");
    send_data(8'h5A);
    finish_scenario("offset_drained");

    // lock abort on a non-COM boundary
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h00);
    chk("abort_active", {7'd0, active}, 8'd0);
    lock4("abort_relock");
    send_data(8'h11);
    finish_scenario("abort_drained");

    // idle filtering, then reset mid-byte
    lock4("idle_active");
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_data(8'h77);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk32f);
    #1;
    chk("idle_drained", 8'(exp_q.size()), 8'd0);
    reset = 1'b0;
    #1;
    chk("midbyte_active", {7'd0, active}, 8'd0);
    chk("midbyte_out", out, 8'h00);
    repeat (2) @(posedge clk32f);
    #1;
    reset = 1'b1;

`ifdef RELOCK_EN
    // one-bit slip: boundaries now see 5E, misaligned COM hits force re-search
    lock4("relock_first");
    send_bit(1'b0);
    exp_q.push_back(8'h5E);
    send_byte(8'hBC);
    chk("slip_hit1_active", {7'd0, active}, 8'd1);
    exp_q.push_back(8'h5E);
    send_byte(8'hBC);
    chk("slip_hit2_active", {7'd0, active}, 8'd0);
    send_byte(8'hBC);
    chk("slip_search_active", {7'd0, active}, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      send_byte(8'hBC);
      chk("relock_active", {7'd0, active}, (k == 3) ? 8'd1 : 8'd0);
    end
    send_data(8'h5A);
    finish_scenario("relock_drained");
`endif

    @(negedge clk32f);
    chk("final_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
